// File: rtl/npu_top.sv
// Streaming dot-product engine: Q8.8 activations times a 256-entry weight
// memory, accumulated per packet and emitted as one saturated Q8.8 result.
module npu_top #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [DATA_WIDTH-1:0] dram_wdata,
    output logic [DATA_WIDTH-1:0] dram_rdata,
    input  logic                  dram_we,
    input  logic                  dram_ce,
    output logic                  dram_ready,
    output logic [31:0]           status,
    output logic                  interrupt
);

    localparam int ACC_W     = 40;
    localparam int PROD_W    = 2 * DATA_WIDTH;
    localparam int MEM_DEPTH = 256;
    localparam int FRAC_BITS = 8;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [7:0]                   widx;
    logic [7:0]                   host_idx;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      acc_sum;
    logic signed [ACC_W-1:0]      acc_shift;
    logic signed [PROD_W-1:0]     product;
    logic [DATA_WIDTH-1:0]        sat_value;
    logic                         sat_hit;
    logic                         sat_flag;
    logic [15:0]                  result_count;
    logic                         beat;
    logic                         out_fire;
    logic                         unused_addr_bits;

    // Only the low address byte decodes; upper bits alias onto the same words.
    assign host_idx         = dram_addr[7:0];
    assign unused_addr_bits = ^dram_addr[ADDR_WIDTH-1:8];

    assign s_axis_tready = (state != OUTPUT);
    assign beat          = s_axis_tvalid && s_axis_tready;
    assign out_fire      = m_axis_tvalid && m_axis_tready;
    assign m_axis_tlast  = m_axis_tvalid;
    assign interrupt     = out_fire;
    assign status        = {result_count, 5'd0, sat_flag, 2'(state), widx};

    // Weight read is combinational, so a same-cycle host write is seen only by later beats.
    assign product   = $signed(s_axis_tdata) * mem[widx];
    assign acc_sum   = acc + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    assign acc_shift = acc_sum >>> FRAC_BITS;

    always_comb begin
        sat_hit   = 1'b0;
        sat_value = acc_shift[DATA_WIDTH-1:0];
        if (acc_shift > SAT_MAX) begin
            sat_hit   = 1'b1;
            sat_value = SAT_MAX[DATA_WIDTH-1:0];
        end else if (acc_shift < SAT_MIN) begin
            sat_hit   = 1'b1;
            sat_value = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (dram_ce && dram_we) begin
            mem[host_idx] <= dram_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dram_rdata <= '0;
            dram_ready <= 1'b0;
        end else begin
            dram_ready <= dram_ce;
            if (dram_ce && !dram_we) begin
                dram_rdata <= mem[host_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, ACCUM: begin
                if (beat) begin
                    next_state = s_axis_tlast ? OUTPUT : ACCUM;
                end
            end
            OUTPUT: begin
                if (m_axis_tready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            widx          <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            sat_flag      <= 1'b0;
            result_count  <= '0;
        end else if (beat) begin
            if (s_axis_tlast) begin
                acc           <= '0;
                widx          <= '0;
                m_axis_tdata  <= sat_value;
                m_axis_tvalid <= 1'b1;
                sat_flag      <= sat_hit;
            end else begin
                acc  <= acc_sum;
                widx <= widx + 8'd1;
            end
        end else if (out_fire) begin
            m_axis_tvalid <= 1'b0;
            result_count  <= result_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_npu_top.sv
// Directed self-checking bench for npu_top: host memory port, packet
// accumulation, saturation, output backpressure and reset discard.
module tb_npu_top;

    localparam int DW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_wdata;
    logic [DW-1:0] dram_rdata;
    logic          dram_we;
    logic          dram_ce;
    logic          dram_ready;
    logic [31:0]   status;
    logic          interrupt;

    int tests_run    = 0;
    int tests_failed = 0;

    npu_top #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .dram_addr     (dram_addr),
        .dram_wdata    (dram_wdata),
        .dram_rdata    (dram_rdata),
        .dram_we       (dram_we),
        .dram_ce       (dram_ce),
        .dram_ready    (dram_ready),
        .status        (status),
        .interrupt     (interrupt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        dram_ce    = 1'b1;
        dram_we    = 1'b1;
        dram_addr  = addr;
        dram_wdata = data;
        tick();
        checkOutput("wr_ready_pulse", 32'(dram_ready), 32'd1);
        dram_ce = 1'b0;
        dram_we = 1'b0;
        tick();
        checkOutput("wr_ready_low", 32'(dram_ready), 32'd0);
    endtask

    task automatic host_read(input logic [AW-1:0] addr, input logic [DW-1:0] expected);
        dram_ce   = 1'b1;
        dram_we   = 1'b0;
        dram_addr = addr;
        tick();
        checkOutput("rd_data", 32'(dram_rdata), 32'(expected));
        checkOutput("rd_ready_pulse", 32'(dram_ready), 32'd1);
        dram_ce = 1'b0;
        tick();
        checkOutput("rd_data_hold", 32'(dram_rdata), 32'(expected));
        checkOutput("rd_ready_low", 32'(dram_ready), 32'd0);
    endtask

    task automatic applyStimulus(input logic [DW-1:0] data, input logic last);
        s_axis_tdata  = data;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Called the cycle after the tlast beat with m_axis_tready low.
    task automatic expect_result(input string tag, input logic [DW-1:0] data,
                                 input logic sat, input logic [15:0] count_after);
        checkOutput({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd1);
        checkOutput({tag, "_tlast"}, 32'(m_axis_tlast), 32'd1);
        checkOutput({tag, "_tdata"}, 32'(m_axis_tdata), 32'(data));
        checkOutput({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
        checkOutput({tag, "_state_out"}, 32'(status[9:8]), 32'd2);
        checkOutput({tag, "_widx_clr"}, 32'(status[7:0]), 32'd0);
        checkOutput({tag, "_sat"}, 32'(status[10]), 32'(sat));
        checkOutput({tag, "_irq_idle"}, 32'(interrupt), 32'd0);
        m_axis_tready = 1'b1;
        #1;
        checkOutput({tag, "_irq"}, 32'(interrupt), 32'd1);
        tick();
        m_axis_tready = 1'b0;
        checkOutput({tag, "_tvalid_drop"}, 32'(m_axis_tvalid), 32'd0);
        checkOutput({tag, "_tlast_drop"}, 32'(m_axis_tlast), 32'd0);
        checkOutput({tag, "_irq_done"}, 32'(interrupt), 32'd0);
        checkOutput({tag, "_state_idle"}, 32'(status[9:8]), 32'd0);
        checkOutput({tag, "_count"}, 32'(status[31:16]), 32'(count_after));
        checkOutput({tag, "_s_tready_back"}, 32'(s_axis_tready), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        dram_addr     = '0;
        dram_wdata    = '0;
        dram_we       = 1'b0;
        dram_ce       = 1'b0;

        #12;
        checkOutput("rst_s_tready", 32'(s_axis_tready), 32'd1);
        checkOutput("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        checkOutput("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
        checkOutput("rst_rdata", 32'(dram_rdata), 32'd0);
        checkOutput("rst_ready", 32'(dram_ready), 32'd0);
        checkOutput("rst_status", status, 32'd0);
        checkOutput("rst_irq", 32'(interrupt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Host port: writes, read-back, and upper-address aliasing.
        host_write(32'h0000_0000, 16'h0100);
        host_write(32'h0000_0001, 16'h0200);
        host_read(32'h0000_0001, 16'h0200);
        host_read(32'hABCD_0100, 16'h0100);

        // 3*1.0 + 4*2.0 = 11, held under backpressure with a rejected beat offered.
        applyStimulus(16'h0003, 1'b0);
        checkOutput("accum_state", 32'(status[9:8]), 32'd1);
        checkOutput("accum_widx", 32'(status[7:0]), 32'd1);
        applyStimulus(16'h0004, 1'b1);
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata  = 16'h0100;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = 1'b1;
            tick();
            checkOutput("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
            checkOutput("hold_tdata", 32'(m_axis_tdata), 32'h000B);
            checkOutput("hold_s_tready", 32'(s_axis_tready), 32'd0);
            checkOutput("hold_widx", 32'(status[7:0]), 32'd0);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        expect_result("r_basic", 16'h000B, 1'b0, 16'd1);

        host_write(32'h0, 16'h7FFF);
        applyStimulus(16'h7FFF, 1'b1);
        expect_result("r_satpos", 16'h7FFF, 1'b1, 16'd2);

        host_write(32'h0, 16'h8000);
        applyStimulus(16'h7FFF, 1'b1);
        expect_result("r_satneg", 16'h8000, 1'b1, 16'd3);

        // -1 * 0.5 = -0.5 -> arithmetic shift floors to -1.
        host_write(32'h0, 16'h0080);
        applyStimulus(16'hFFFF, 1'b1);
        expect_result("r_neg", 16'hFFFF, 1'b0, 16'd4);

        // Same-cycle weight write: beat must use the old weight 1.0.
        host_write(32'h0, 16'h0100);
        dram_ce       = 1'b1;
        dram_we       = 1'b1;
        dram_addr     = 32'h0;
        dram_wdata    = 16'h0200;
        s_axis_tdata  = 16'h0004;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        tick();
        dram_ce       = 1'b0;
        dram_we       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        expect_result("r_oldw", 16'h0004, 1'b0, 16'd5);
        host_read(32'h0, 16'h0200);

        // No tlast: keep accumulating, never emit.
        applyStimulus(16'h1234, 1'b0);
        applyStimulus(16'h5678, 1'b0);
        tick();
        tick();
        checkOutput("notlast_widx", 32'(status[7:0]), 32'd2);
        checkOutput("notlast_state", 32'(status[9:8]), 32'd1);
        checkOutput("notlast_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Mid-packet reset discards the partial sum.
        rst_n = 1'b0;
        #1;
        checkOutput("midpkt_rst_status", status, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        host_write(32'h1, 16'h0200);
        applyStimulus(16'h0100, 1'b1);
        expect_result("r_after_rst", 16'h0200, 1'b0, 16'd1);

        // Mid-OUTPUT reset drops the pending result with no interrupt.
        applyStimulus(16'h0100, 1'b1);
        checkOutput("pend_tvalid", 32'(m_axis_tvalid), 32'd1);
        m_axis_tready = 1'b1;
        rst_n         = 1'b0;
        #1;
        checkOutput("midout_irq", 32'(interrupt), 32'd0);
        checkOutput("midout_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("midout_status", status, 32'd0);
        tick();
        checkOutput("midout_irq_hold", 32'(interrupt), 32'd0);
        rst_n         = 1'b1;
        m_axis_tready = 1'b0;
        tick();
        checkOutput("midout_status_after", status, 32'd0);

        // Weight index wraps 255 -> 0 after 256 beats.
        s_axis_tdata  = 16'h0000;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
        end
        s_axis_tvalid = 1'b0;
        checkOutput("wrap_widx", 32'(status[7:0]), 32'd0);
        checkOutput("wrap_state", 32'(status[9:8]), 32'd1);
        applyStimulus(16'h0000, 1'b1);
        expect_result("r_wrap", 16'h0000, 1'b0, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/npu_top.md
NPU_TOP -- requirements
Module: npu_top

Interface
REQ-001 DATA_WIDTH, 16, stream and memory data width SHALL be a parameter with this default.
REQ-002 ADDR_WIDTH, 32, host memory-port address width SHALL be a parameter with this default.
REQ-003 The block SHALL have exactly these ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_axis_tdata  input  DATA_WIDTH  signed input activation.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input beat accepted when high with tvalid.
- s_axis_tlast  input  1  last beat of vector.
- m_axis_tdata  output  DATA_WIDTH  signed result.
- m_axis_tvalid  output  1  result valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  result beat marker.
- dram_addr  input  ADDR_WIDTH  host word address into weight memory.
- dram_wdata  input  DATA_WIDTH  host write data.
- dram_rdata  output  DATA_WIDTH  host read data.
- dram_we  input  1  write enable, qualified by dram_ce.
- dram_ce  input  1  host access strobe.
- dram_ready  output  1  access-complete pulse.
- status  output  32  status word.
- interrupt  output  1  result-done pulse.

Function
REQ-004 Weight memory: 256 x 16-bit signed, Q8.8; only dram_addr[7:0] SHALL decode (upper bits alias).
REQ-005 dram_ce=1, dram_we=1 SHALL write dram_wdata at the clock edge; dram_ce=1, dram_we=0 SHALL load dram_rdata with the addressed word at the edge; dram_rdata SHALL hold otherwise.
REQ-006 dram_ready SHALL be 1 for exactly the cycle after every cycle with dram_ce=1, else 0.
REQ-007 FSM states IDLE(0), ACCUM(1), OUTPUT(2); s_axis_tready=1 in IDLE/ACCUM, 0 in OUTPUT.
REQ-008 Accepted beat (tvalid and tready): acc += x * mem[widx] (signed 16x16 -> 32, 40-bit signed accumulator); widx increments, wrapping 255 -> 0; IDLE -> ACCUM.
REQ-009 Accepted beat with tlast: that beat SHALL be included; next cycle state=OUTPUT, m_axis_tvalid=1, m_axis_tlast=1, m_axis_tdata=saturate16(acc_final >>> 8) (arithmetic shift, clamp to [-32768, 32767]); acc and widx cleared.
REQ-010 In OUTPUT, m_axis_tdata/tvalid/tlast SHALL hold stable until m_axis_tready=1; on that handshake cycle, interrupt=1 for one cycle, result count increments, and state returns to IDLE on the next cycle.
REQ-011 m_axis_tlast SHALL equal m_axis_tvalid.
REQ-012 Host write to mem[widx] in the same cycle as a stream beat: the beat SHALL use the old weight.
REQ-013 status[7:0]=widx, status[9:8]=state, status[10]=saturation flag of most recent result (set/cleared when result is produced), status[15:11]=0, status[31:16]=result count, wrapping at 65535.
REQ-014 Beats without tlast SHALL never produce output; accumulation continues indefinitely.

Reset
REQ-015 rst_n low SHALL immediately clear state to IDLE, acc, widx, result count, saturation flag, dram_rdata, dram_ready, m_axis_tdata/tvalid/tlast, and interrupt to 0; s_axis_tready=1 once state is IDLE; weight memory contents SHALL be left uninitialised.
REQ-016 Reset mid-packet or mid-OUTPUT SHALL discard the partial or pending result with no interrupt.

Verification
REQ-017 Reset: assert rst_n=0 -> all outputs 0 except s_axis_tready=1, status=0.
REQ-018 Write mem[0]=0x0100, mem[1]=0x0200, then read addr 1 -> dram_rdata=0x0200, with dram_ready pulsing one cycle after each ce.
REQ-019 Stream 0x0003, then 0x0004 with tlast -> m_axis_tdata=0x000B, tlast=1, interrupt pulse, status[31:16]=1.
REQ-020 Set mem[0]=0x7FFF; stream 0x7FFF with tlast -> m_axis_tdata=0x7FFF, status[10]=1.
REQ-021 Hold m_axis_tready=0 -> tvalid and data held and s_axis_tready=0; release -> single handshake, then IDLE.
REQ-022 Stream 0x1234 then 0x5678 with no tlast -> no m_axis_tvalid, status[7:0]=2, status[9:8]=1.
